// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 panel-init arbiter: FSM state encoding,
// pin-bundle layout, idle (blank) pin levels and the state-to-mux mapping.
package hub75_pkg;

   typedef enum logic [1:0] {
      S_KICK   = 2'd0,
      S_RUN    = 2'd1,
      S_GUARD  = 2'd2,
      S_NORMAL = 2'd3
   } hub75_arb_state_e;

   typedef enum logic [1:0] {
      PIN_SEL_IDLE = 2'd0,
      PIN_SEL_INIT = 2'd1,
      PIN_SEL_DISP = 2'd2
   } hub75_pin_sel_e;

   // One HUB75 pin bundle; moved as a unit so sources can never mix.
   typedef struct packed {
      logic [2:0] rgb1;
      logic [2:0] rgb2;
      logic       latch;
      logic       mask_en;
      logic       pixclock;
   } hub75_pins_t;

   // Blank panel: no colour, no latch, no clock, outputs masked.
   localparam logic [2:0] HUB75_IDLE_RGB      = 3'b000;
   localparam logic       HUB75_IDLE_LATCH    = 1'b0;
   localparam logic       HUB75_IDLE_MASK_EN  = 1'b1;
   localparam logic       HUB75_IDLE_PIXCLOCK = 1'b0;

   localparam hub75_pins_t HUB75_IDLE_PINS = '{
      rgb1:     HUB75_IDLE_RGB,
      rgb2:     HUB75_IDLE_RGB,
      latch:    HUB75_IDLE_LATCH,
      mask_en:  HUB75_IDLE_MASK_EN,
      pixclock: HUB75_IDLE_PIXCLOCK
   };

   // Length of the init-sequencer reset pulse issued in S_KICK.
   localparam int KICK_CYCLES = 2;

   // Which source owns the pins while the FSM sits in a given state.
   function automatic hub75_pin_sel_e hub75_state_to_sel(input hub75_arb_state_e st);
      hub75_pin_sel_e sel;
      case (st)
         S_RUN:    sel = PIN_SEL_INIT;
         S_NORMAL: sel = PIN_SEL_DISP;
         default:  sel = PIN_SEL_IDLE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/hub75_pin_mux.sv
// Registered HUB75 pin multiplexer. The select picks the whole pin bundle
// from either the init sequencer, the display pipeline or the idle levels,
// and the chosen bundle appears on the pins one cycle later.
module hub75_pin_mux
   import hub75_pkg::*;
(
   input  logic           clk_in,
   input  logic           reset,
   input  hub75_pin_sel_e sel,
   input  hub75_pins_t    init_pins,
   input  hub75_pins_t    disp_pins,
   output hub75_pins_t    pins
);

   hub75_pins_t pins_reg;

   // Capture the selected bundle as a whole; reset parks the panel blank.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         pins_reg <= HUB75_IDLE_PINS;
      end else begin
         case (sel)
            PIN_SEL_INIT: pins_reg <= init_pins;
            PIN_SEL_DISP: pins_reg <= disp_pins;
            default:      pins_reg <= HUB75_IDLE_PINS;
         endcase
      end
   end

   assign pins = pins_reg;

endmodule

// File: rtl/hub75_init_arbiter.sv
// HUB75 panel-init arbiter. Kicks the panel-init sequencer, lets it drive the
// pins until it reports completion (or a timeout expires), blanks the panel
// for a guard interval and then hands the pins to the display pipeline.
// Optional feature macro: FM6126_REINIT_EN -- periodic re-initialisation,
// triggered on a frame boundary once REINIT_PERIOD cycles of display elapsed.
// Without the macro S_NORMAL is terminal until reset.
module hub75_init_arbiter
   import hub75_pkg::*;
#(
   parameter int GUARD_CYCLES   = 16,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int REINIT_PERIOD  = 1000000
)
(
   input  logic       clk_in,
   input  logic       reset,
   // panel-init sequencer
   input  logic [2:0] init_rgb1,
   input  logic [2:0] init_rgb2,
   input  logic       init_latch,
   input  logic       init_mask_en,
   input  logic       init_pixclock,
   input  logic       init_reset_notify,
   // display scan pipeline
   input  logic [2:0] disp_rgb1,
   input  logic [2:0] disp_rgb2,
   input  logic       disp_latch,
   input  logic       disp_mask_en,
   input  logic       disp_pixclock,
   input  logic       disp_frame_start,
   // HUB75 pins
   output logic [2:0] rgb1_out,
   output logic [2:0] rgb2_out,
   output logic       latch_out,
   output logic       mask_en,
   output logic       pixclock_out,
   // control / status
   output logic       init_reset,
   output logic       disp_reset,
   output logic       init_done,
   output logic       init_timeout
);

   localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]  GUARD_LAST = 8'(GUARD_CYCLES - 1);
   localparam logic        KICK_LAST  = 1'(KICK_CYCLES - 1);

   hub75_arb_state_e state_reg;
   logic             kick_cnt_reg;
   logic [15:0]      tmo_cnt_reg;
   logic [7:0]       guard_cnt_reg;
   logic             init_reset_reg;
   logic             disp_reset_reg;
   logic             init_done_reg;
   logic             init_timeout_reg;
   logic             reinit_fire;

   hub75_pins_t      init_pins;
   hub75_pins_t      disp_pins;
   hub75_pins_t      pins;
   hub75_pin_sel_e   pin_sel;

`ifdef FM6126_REINIT_EN
   localparam logic [31:0] REINIT_LAST = 32'(REINIT_PERIOD - 1);

   logic [31:0] period_cnt_reg;

   // Re-init only at a frame boundary, once the period has elapsed.
   assign reinit_fire = (state_reg == S_NORMAL) &&
                        (period_cnt_reg >= REINIT_LAST) &&
                        disp_frame_start;

   // Period counter runs only while displaying; saturates rather than wraps.
   always_ff @(posedge clk_in) begin
      if (reset || (state_reg != S_NORMAL) || reinit_fire) begin
         period_cnt_reg <= 32'd0;
      end else if (period_cnt_reg != 32'hFFFF_FFFF) begin
         period_cnt_reg <= period_cnt_reg + 32'd1;
      end
   end
`else
   logic unused_reinit_inputs;

   assign reinit_fire          = 1'b0;
   assign unused_reinit_inputs = disp_frame_start & (REINIT_PERIOD > 0);
`endif

   // Sequencing FSM; every status output is registered alongside the state.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_reg        <= S_KICK;
         kick_cnt_reg     <= 1'b0;
         tmo_cnt_reg      <= 16'd0;
         guard_cnt_reg    <= 8'd0;
         init_reset_reg   <= 1'b1;
         disp_reset_reg   <= 1'b1;
         init_done_reg    <= 1'b0;
         init_timeout_reg <= 1'b0;
      end else begin
         case (state_reg)
            S_KICK: begin
               init_reset_reg <= 1'b1;
               disp_reset_reg <= 1'b1;
               init_done_reg  <= 1'b0;
               if (kick_cnt_reg == KICK_LAST) begin
                  state_reg      <= S_RUN;
                  kick_cnt_reg   <= 1'b0;
                  tmo_cnt_reg    <= 16'd0;
                  init_reset_reg <= 1'b0;
               end else begin
                  kick_cnt_reg <= kick_cnt_reg + 1'b1;
               end
            end

            S_RUN: begin
               disp_reset_reg <= 1'b1;
               // Completion beats a coincident timeout.
               if (init_reset_notify) begin
                  state_reg        <= S_GUARD;
                  guard_cnt_reg    <= 8'd0;
                  init_reset_reg   <= 1'b1;
                  init_timeout_reg <= 1'b0;
               end else if (tmo_cnt_reg == TMO_LAST) begin
                  state_reg        <= S_GUARD;
                  guard_cnt_reg    <= 8'd0;
                  init_reset_reg   <= 1'b1;
                  init_timeout_reg <= 1'b1;
               end else if (tmo_cnt_reg != 16'hFFFF) begin
                  tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
               end
            end

            S_GUARD: begin
               init_reset_reg <= 1'b1;
               if (guard_cnt_reg == GUARD_LAST) begin
                  state_reg      <= S_NORMAL;
                  disp_reset_reg <= 1'b0;
                  init_done_reg  <= 1'b1;
               end else begin
                  disp_reset_reg <= 1'b1;
                  if (guard_cnt_reg != 8'hFF) begin
                     guard_cnt_reg <= guard_cnt_reg + 8'd1;
                  end
               end
            end

            S_NORMAL: begin
               init_reset_reg <= 1'b1;
               if (reinit_fire) begin
                  state_reg      <= S_KICK;
                  kick_cnt_reg   <= 1'b0;
                  disp_reset_reg <= 1'b1;
                  init_done_reg  <= 1'b0;
               end else begin
                  disp_reset_reg <= 1'b0;
                  init_done_reg  <= 1'b1;
               end
            end

            default: begin
               state_reg <= S_KICK;
            end
         endcase
      end
   end

   // Gather the two sources into pin bundles for the mux.
   assign init_pins = '{
      rgb1:     init_rgb1,
      rgb2:     init_rgb2,
      latch:    init_latch,
      mask_en:  init_mask_en,
      pixclock: init_pixclock
   };

   assign disp_pins = '{
      rgb1:     disp_rgb1,
      rgb2:     disp_rgb2,
      latch:    disp_latch,
      mask_en:  disp_mask_en,
      pixclock: disp_pixclock
   };

   // The select follows the registered state, so the pins change owner only
   // on a state edge.
   assign pin_sel = hub75_state_to_sel(state_reg);

   hub75_pin_mux u_pin_mux (
      .clk_in    (clk_in),
      .reset     (reset),
      .sel       (pin_sel),
      .init_pins (init_pins),
      .disp_pins (disp_pins),
      .pins      (pins)
   );

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_rgb
         assign rgb1_out[gi] = pins.rgb1[gi];
         assign rgb2_out[gi] = pins.rgb2[gi];
      end
   endgenerate

   assign latch_out    = pins.latch;
   assign mask_en      = pins.mask_en;
   assign pixclock_out = pins.pixclock;

   assign init_reset   = init_reset_reg;
   assign disp_reset   = disp_reset_reg;
   assign init_done    = init_done_reg;
   assign init_timeout = init_timeout_reg;

endmodule
